seg_display_scheduler: RTL and testbench
========================================

# seg_display_scheduler

Time-shares the board's two-digit seven-segment display between one live value source and several event sources, and feeds the selected value to the hex-to-two-digit decoder as its 32-bit `i_hex` input. Source 0 is shown continuously by default. Sources 1..N_SRC-1 post one-shot display requests, which are queued and shown for a fixed hold time each, blinking, in round-robin order. It sits between game/timer logic and the decoder in the DE2-115 top level.

## Interface
- `N_SRC`, default 4 — number of sources, including live source 0; range 2..8.
- `HOLD_CYCLES`, default 50_000_000 — cycles each event value stays on the display; must be ≥ 2.
- `BLINK_CYCLES`, default 12_500_000 — half-period of the blink during an event display; must be ≥ 1.
- `i_clk`  in  1  — the block's only clock.
- `i_rst`  in  1  — reset; synchronous, active-high.
- `i_req`  in  N_SRC  — one-cycle request pulse per source. Bit 0 is ignored.
- `i_value`  in  7*N_SRC  — packed values; source k occupies [7k+6:7k].
- `o_hex`  out  32  — value to the decoder, always 0..99: {25'b0, value7}.
- `o_blank`  out  1  — 1 means the display must be driven dark (top level forces all segments to 1).
- `o_grant`  out  N_SRC  — one-hot index of the event source being shown; all zero while in IDLE.
- `o_busy`  out  1  — 1 while in SHOW.

## Operation
- **Clamp.** Any 7-bit value above 99 is clamped to 99 wherever it is captured or passed through.
- **Request capture.** `i_req[k]=1` (k ≥ 1) sets `pending[k]` and captures the clamped `i_value[k]` into `lat[k]`.
  - Re-requesting while pending overwrites `lat[k]`. The request is not queued twice.
- **States.** Two states: IDLE and SHOW.
- **IDLE.**
  - `o_hex` = clamped `i_value[0]`, registered, so 1-cycle latency.
  - `o_grant`=0, `o_blank`=0, `o_busy`=0.
  - If `pending` ≠ 0, select the next source round-robin and go to SHOW.
- **Round-robin selection.** Search indices 1..N_SRC-1, starting at `rr_ptr+1` and wrapping from N_SRC-1 back to 1. The first pending index found wins, and `rr_ptr` is set to it.
- **SHOW, source s.**
  - `o_hex` = {25'b0, `lat[s]`}, `o_grant` = 1<<s, `o_busy`=1.
  - Hold counter is loaded with HOLD_CYCLES-1 on entry and decrements each cycle.
  - When the counter is 0, clear `pending[s]` and return to IDLE.
  - SHOW lasts exactly HOLD_CYCLES cycles.
  - At least one IDLE cycle always separates two SHOW periods.
- **Blink.**
  - A blink counter is reset on SHOW entry.
  - `o_blank` = 0 for the first BLINK_CYCLES cycles of SHOW, then 1 for BLINK_CYCLES cycles, repeating.
- **Re-request of the source being shown** (`i_req[s]` during SHOW of s):
  - `lat[s]` updates and `o_hex` shows the new value the next cycle.
  - The hold counter reloads to HOLD_CYCLES-1. Blink phase is not reset.
- **Simultaneous set and clear.** A request on the same cycle that clears `pending[s]` wins: the bit stays set and s is served again later in round-robin order.
- **Reset values** (apply on the edge where `i_rst`=1, including mid-SHOW):
  - state IDLE, `pending`=0, all `lat`=0, `rr_ptr`=N_SRC-1 (so source 1 is served first), counters 0.
  - `o_hex`=0, `o_blank`=0, `o_grant`=0, `o_busy`=0.
  - Requests are ignored while `i_rst`=1.

## Timing
- All outputs are registered and none is combinational from inputs.
- With a request pulse at cycle t while idle and nothing pending:
  - t+1: `pending` set.
  - t+2: SHOW, with `o_grant`/`o_hex`/`o_busy` valid.
  - t+2+HOLD_CYCLES: first IDLE cycle.
- Live source 0 change at cycle t appears on `o_hex` at t+1 while in IDLE.
- Decoder output is combinational from `o_hex`, so segments follow with no extra cycle.

## Test plan
All scenarios use N_SRC=4, HOLD_CYCLES=8, BLINK_CYCLES=2.
- **Reset/live.** Hold `i_rst` 3 cycles; all outputs 0. Release, set `i_value[0]`=42 → `o_hex`=42 one cycle later; set 127 → `o_hex`=99; `o_busy` stays 0.
- **Single event.** Pulse `i_req[2]` with `i_value[2]`=17 at t → at t+2 `o_grant`=4'b0100, `o_hex`=17, `o_busy`=1 for exactly 8 cycles. `o_blank` pattern over those 8 cycles is 0,0,1,1,0,0,1,1. Then `o_hex` returns to `i_value[0]`.
- **Round-robin.** Pulse `i_req[1]`, `[2]`, `[3]` on the same cycle with values 11, 22, 33 → served in order 1, 2, 3 with one IDLE cycle between each. Then pulse 3 and 1 together → served 1 first (pointer wrap after 3).
- **Re-request during show.** While source 1 shows 11 at hold count 3, pulse `i_req[1]` with 55 → `o_hex`=55 next cycle and SHOW lasts 8 more cycles.
- **Set/clear collision.** `i_req[2]` on the last SHOW cycle of source 2 → after one IDLE cycle, source 2 is shown again with the new value.
- **Reset mid-SHOW.** Assert `i_rst` during SHOW with sources 2 and 3 pending → next cycle all outputs 0, `pending` empty, and no SHOW occurs after release.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// Time-shares the two-digit seven-segment display between live source 0 and
// queued one-shot event sources 1..N_SRC-1, served round-robin with a blinking hold.
module seg_display_scheduler #(
    parameter int N_SRC        = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_SRC-1:0]     i_req,
    input  logic [7*N_SRC-1:0]   i_value,
    output logic [31:0]          o_hex,
    output logic                 o_blank,
    output logic [N_SRC-1:0]     o_grant,
    output logic                 o_busy
);

    localparam int IW = $clog2(N_SRC);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    function automatic logic [6:0] clamp99(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    state_t                  state_q, state_d;
    logic [N_SRC-1:0]        pending_q, pending_d;
    logic [N_SRC-1:0][6:0]   lat_q, lat_d;
    logic [IW-1:0]           sel_q, sel_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [6:0]              hex_q, hex_d;
    logic                    blank_q, blank_d;
    logic [N_SRC-1:0]        grant_q, grant_d;
    logic                    busy_q, busy_d;

    logic                    found;
    logic [IW-1:0]           pick;
    logic [IW-1:0]           idx_v;
    int                      idx;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        lat_d       = lat_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        hex_d       = clamp99(i_value[6:0]);
        blank_d     = 1'b0;
        grant_d     = '0;
        busy_d      = 1'b0;
        found       = 1'b0;
        pick        = '0;
        idx         = 0;
        idx_v       = '0;

        // Round-robin search over 1..N_SRC-1 starting after the last winner.
        for (int off = 1; off < N_SRC; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= N_SRC) idx = idx - (N_SRC - 1);
            idx_v = IW'(idx);
            if (!found && pending_q[idx_v]) begin
                found = 1'b1;
                pick  = idx_v;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = SHOW;
                    sel_d       = pick;
                    rr_ptr_d    = pick;
                    hold_d      = HOLD_LOAD;
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
                end
            end
            SHOW: begin
                if (hold_q == '0) begin
                    state_d          = IDLE;
                    pending_d[sel_q] = 1'b0;
                end else if (i_req[sel_q]) begin
                    hold_d = HOLD_LOAD;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = ~blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture after the clear so a request on the clearing cycle keeps the bit set.
        for (int k = 1; k < N_SRC; k++) begin
            if (i_req[k]) begin
                pending_d[k] = 1'b1;
                lat_d[k]     = clamp99(i_value[7*k +: 7]);
            end
        end

        if (state_d == SHOW) begin
            hex_d          = lat_d[sel_d];
            blank_d        = blink_ph_d;
            busy_d         = 1'b1;
            grant_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            lat_q       <= '0;
            sel_q       <= '0;
            rr_ptr_q    <= IW'(N_SRC - 1);
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            hex_q       <= '0;
            blank_q     <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            lat_q       <= lat_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            hex_q       <= hex_d;
            blank_q     <= blank_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    assign o_hex   = {25'b0, hex_q};
    assign o_blank = blank_q;
    assign o_grant = grant_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with N_SRC=4, HOLD_CYCLES=8, BLINK_CYCLES=2.
module tb_seg_display_scheduler;

    localparam int N = 4;

    logic           i_clk;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [7*N-1:0] i_value;
    logic [31:0]    o_hex;
    logic           o_blank;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    int total = 0;
    int bad   = 0;

    seg_display_scheduler #(.N_SRC(N), .HOLD_CYCLES(8), .BLINK_CYCLES(2)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_value (i_value),
        .o_hex   (o_hex),
        .o_blank (o_blank),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic setv(input int k, input logic [6:0] v);
        i_value[7*k +: 7] = v;
    endtask

    task automatic pulse(input logic [N-1:0] r);
        i_req = r;
        tick();
        i_req = '0;
    endtask

    task automatic chk_idle(input logic [31:0] live);
        chk("idle_hex",   o_hex,   live);
        chk("idle_grant", {28'b0, o_grant}, 32'd0);
        chk("idle_busy",  {31'b0, o_busy},  32'd0);
        chk("idle_blank", {31'b0, o_blank}, 32'd0);
    endtask

    // Checks n SHOW cycles of source src; blink phase counted from cycle off of the SHOW.
    task automatic show_chk(input int src, input logic [31:0] v, input int n, input int off);
        for (int i = 0; i < n; i++) begin
            chk("show_grant", {28'b0, o_grant}, 32'(1 << src));
            chk("show_hex",   o_hex, v);
            chk("show_busy",  {31'b0, o_busy}, 32'd1);
            chk("show_blank", {31'b0, o_blank}, 32'(((i + off) / 2) % 2));
            tick();
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_req   = '0;
        i_value = '0;

        // Reset and live pass-through
        tick(); tick(); tick();
        chk("rst_hex",   o_hex, 32'd0);
        chk("rst_blank", {31'b0, o_blank}, 32'd0);
        chk("rst_grant", {28'b0, o_grant}, 32'd0);
        chk("rst_busy",  {31'b0, o_busy},  32'd0);
        i_rst = 1'b0;
        setv(0, 7'd42);
        tick();
        chk("live42", o_hex, 32'd42);
        setv(0, 7'd127);
        tick();
        chk("live_clamp", o_hex, 32'd99);
        chk("live_busy", {31'b0, o_busy}, 32'd0);

        // Single event with blink pattern
        setv(0, 7'd5);
        setv(2, 7'd17);
        pulse(4'b0100);
        chk("pend_not_shown", {31'b0, o_busy}, 32'd0);
        tick();
        show_chk(2, 32'd17, 8, 0);
        chk_idle(32'd5);

        // Round-robin from a fresh reset
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        setv(1, 7'd11); setv(2, 7'd22); setv(3, 7'd33);
        pulse(4'b1110);
        tick();
        show_chk(1, 32'd11, 8, 0);
        chk_idle(32'd5);
        tick();
        show_chk(2, 32'd22, 8, 0);
        chk_idle(32'd5);
        tick();
        show_chk(3, 32'd33, 8, 0);
        chk_idle(32'd5);
        tick();
        chk_idle(32'd5);
        setv(1, 7'd44); setv(3, 7'd120);
        pulse(4'b1010);
        tick();
        show_chk(1, 32'd44, 8, 0);
        chk_idle(32'd5);
        tick();
        show_chk(3, 32'd99, 8, 0);
        chk_idle(32'd5);

        // Re-request of the shown source at hold count 3
        setv(1, 7'd11);
        pulse(4'b0010);
        tick();
        show_chk(1, 32'd11, 4, 0);
        chk("rereq_pre_hex", o_hex, 32'd11);
        setv(1, 7'd55);
        pulse(4'b0010);
        show_chk(1, 32'd55, 8, 5);
        chk_idle(32'd5);

        // Set/clear collision on the last SHOW cycle
        setv(2, 7'd22);
        pulse(4'b0100);
        tick();
        show_chk(2, 32'd22, 7, 0);
        chk("coll_last_hex", o_hex, 32'd22);
        setv(2, 7'd77);
        pulse(4'b0100);
        chk_idle(32'd5);
        tick();
        show_chk(2, 32'd77, 8, 0);
        chk_idle(32'd5);

        // Reset mid-SHOW with 2 and 3 pending
        setv(2, 7'd20); setv(3, 7'd30);
        pulse(4'b1100);
        tick();
        chk("mid_busy", {31'b0, o_busy}, 32'd1);
        tick(); tick();
        i_rst = 1'b1;
        tick();
        chk("mrst_hex",   o_hex, 32'd0);
        chk("mrst_blank", {31'b0, o_blank}, 32'd0);
        chk("mrst_grant", {28'b0, o_grant}, 32'd0);
        chk("mrst_busy",  {31'b0, o_busy},  32'd0);
        i_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("post_rst_busy", {31'b0, o_busy}, 32'd0);
        end
        chk("post_rst_hex", o_hex, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
